roulette_spin_sequencer: RTL and testbench
==========================================

# roulette_spin_sequencer

Sequences one roulette spin: accepts a spin request with a target pocket and animates `led_number` around the wheel. Spin phase runs at a constant step rate for a fixed number of laps, then decelerates and lands exactly on the target. Sits between the keyboard command decode / processor-supplied target and the LED decoder that drives the roulette ring. It owns the only write path to the ring position, so the processor and keyboard never drive the LEDs directly.

## Interface
Parameters:
- `NUM_POCKETS`, 38: pockets on the wheel; positions are 0..NUM_POCKETS-1.
- `BASE_DIV`, 2_500_000: clocks per step during the spin phase (≥2).
- `STEP_INC`, 250_000: clocks added to the step interval on each decel step.
- `MIN_LAPS`, 3: full laps in the spin phase (≥1).
- `HOLD_CYCLES`, 100_000_000: clocks the result is shown before returning to idle.
- `BLINK_DIV`, 12_500_000: half-period of the result blink; used only with `ROULETTE_BLINK_EN`.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `spin_req`, in, 1: one-cycle request from keyboard decode.
- `target`, in, 6: landing pocket; sampled with `spin_req`.
- `target_valid`, in, 1: `target` is meaningful; a request is ignored when this is low.
- `led_number`, out, 6: ring position code to the LED decoder.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the wheel lands.
- `result`, out, 6: last landed pocket; holds until the next landing.

## Operation
- States: IDLE, SPIN, DECEL, HOLD.
- **IDLE**
  - `spin_req && target_valid && target<NUM_POCKETS`: latch `target`, load interval=BASE_DIV, clear lap count, go to SPIN.
  - An out-of-range target or a low `target_valid` is ignored; state does not change.
- **SPIN**
  - Every interval clocks, position advances by one (NUM_POCKETS-1 wraps to 0).
  - The lap count increments each time position returns to its value at accept.
  - After MIN_LAPS laps: go to DECEL, with the interval for the next step = BASE_DIV+STEP_INC.
- **DECEL**
  - Each step adds STEP_INC to the interval for the following step.
  - Stop at the first step where position==latched target. At least one decel step is always taken, so target==start position costs a full extra lap.
  - On landing: `result`=target, `done` pulses, go to HOLD.
- **HOLD**
  - Lasts HOLD_CYCLES clocks, then go to IDLE.
- **Arithmetic**
  - Interval register is 32-bit unsigned and saturates at 2^32-1; it never wraps.
  - Position compare is an equality on 6 bits.
- **Boundary cases**
  - `spin_req` while busy is ignored; no queueing.
  - A `target` change after accept has no effect.
  - Async reset mid-spin aborts the spin immediately; the next accepted spin starts from position 0.
- **Reset values**
  - `led_number`=0, `result`=0, `busy`=0, `done`=0, state=IDLE, interval=BASE_DIV, counters=0.

## Timing
- Accept: `busy` rises the cycle after `spin_req`.
- First SPIN step: `led_number` changes BASE_DIV clocks after the accept edge.
- Step k in DECEL (k≥1) occurs BASE_DIV+k·STEP_INC clocks after the previous step.
- `done` asserts in the same cycle that `led_number` reaches the target; `result` updates on that edge.
- `busy` falls exactly HOLD_CYCLES clocks after `done`.
- Total spin latency = MIN_LAPS·NUM_POCKETS·BASE_DIV + Σ decel intervals + HOLD_CYCLES.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ROULETTE_BLINK_EN` defined:
  - During HOLD, `led_number` alternates between `result` and blank code 6'h3F every BLINK_DIV clocks, starting with `result`.
  - Returns steady to `result` in IDLE.
- Undefined:
  - `led_number` shows `result` steadily in HOLD.
  - No blink counter is synthesized.

## Structure
- Shared package `roulette_pkg`:
  - Constants: pocket-code width (6), default NUM_POCKETS, BLANK_CODE=6'h3F.
  - Typedef: state enum.
  - The LED decoder and keyboard decode use the same package.
- Sub-module `step_timer`:
  - Loadable 32-bit down-counter with a one-cycle terminal pulse.
  - Used for step intervals, HOLD, and the blink counter.
- The FSM, position counter and lap counter stay in the top module.

## Test plan
Bench parameters unless stated otherwise: NUM_POCKETS=38, BASE_DIV=4, STEP_INC=2, MIN_LAPS=1, HOLD_CYCLES=10, BLINK_DIV=3.
- **Nominal spin**
  - Stimulus: from reset, `spin_req` with target=5.
  - Required: 38 steps at 4 clocks each (152 clocks), then decel intervals 6,8,10,12,14 (50 clocks). `done` at accept+202 with `result`=5. `busy` low 10 clocks later.
- **Target equals start**
  - Stimulus: target=0 from position 0.
  - Required: one SPIN lap plus a full 38-step DECEL lap, then land on 0.
- **Request while busy**
  - Stimulus: second `spin_req` (target=9) mid-SPIN.
  - Required: ignored; lands on the first target. A request in IDLE afterward is accepted.
- **Invalid request**
  - Stimulus: `target_valid`=0, or target=40.
  - Required: `busy` stays 0 and `led_number` is unchanged.
- **Reset mid-DECEL**
  - Stimulus: drive `reset` low mid-DECEL.
  - Required: all outputs return to reset values asynchronously; the next spin starts from 0.
- **Blink (`ROULETTE_BLINK_EN`)**
  - Stimulus: land on 5 with the macro defined.
  - Required: during HOLD, `led_number` sequence is 5,5,5,3F,3F,3F,5…

Source files
------------

// File: rtl/roulette_pkg.sv
// Shared roulette definitions: pocket-code width, blank LED code, FSM state
// encoding and a saturating 32-bit add used for the step interval.
// The LED decoder and keyboard decode import this package as well.
package roulette_pkg;

    localparam int                CODE_W              = 6;
    localparam int                DEFAULT_NUM_POCKETS = 38;
    localparam logic [CODE_W-1:0] BLANK_CODE          = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPIN,
        ST_DECEL,
        ST_HOLD
    } state_t;

    // Interval arithmetic clamps at all-ones so a very long deceleration
    // never wraps back to a short interval.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable 32-bit down-counter. tick is high for the single cycle in which the
// count is 1, so a load of N produces tick N-1 cycles later and the owner acts
// on the N-th clock edge after the load. Without a reload it parks at 0.
module step_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic        tick
);

    logic [31:0] count;

    // Down-count with load priority; stop at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign tick = (count == 32'd1);

endmodule

// File: rtl/roulette_spin_sequencer.sv
// Roulette spin sequencer: accepts a spin request, steps the ring position at
// a constant rate for MIN_LAPS laps, decelerates one STEP_INC per step and
// lands on the latched target, then shows the result for HOLD_CYCLES.
// Optional feature macro: ROULETTE_BLINK_EN (blink the result during HOLD).
module roulette_spin_sequencer
    import roulette_pkg::*;
#(
    parameter int NUM_POCKETS = DEFAULT_NUM_POCKETS,
    parameter int BASE_DIV    = 2_500_000,
    parameter int STEP_INC    = 250_000,
    parameter int MIN_LAPS    = 3,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int BLINK_DIV   = 12_500_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spin_req,
    input  logic [CODE_W-1:0] target,
    input  logic              target_valid,
    output logic [CODE_W-1:0] led_number,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] result
);

    localparam logic [31:0]       BASE_IV  = 32'(BASE_DIV);
    localparam logic [31:0]       INC_IV   = 32'(STEP_INC);
    localparam logic [31:0]       HOLD_IV  = 32'(HOLD_CYCLES);
    localparam logic [31:0]       LAST_LAP = 32'(MIN_LAPS - 1);
    localparam logic [CODE_W-1:0] LAST_POS = CODE_W'(NUM_POCKETS - 1);

    state_t            state;
    logic [CODE_W-1:0] position;
    logic [CODE_W-1:0] start_pos;
    logic [CODE_W-1:0] target_latched;
    logic [31:0]       interval;
    logic [31:0]       lap_count;

    logic              accept;
    logic              step_tick;
    logic              lap_wrap;
    logic              laps_done;
    logic              landing;
    logic [CODE_W-1:0] pos_adv;
    logic [31:0]       decel_interval;
    logic              step_load;
    logic [31:0]       step_value;

    // Step decisions and the reload value for the shared step/hold timer.
    always_comb begin
        accept         = (state == ST_IDLE) && spin_req && target_valid
                         && (32'(target) < 32'(NUM_POCKETS));
        pos_adv        = (position == LAST_POS) ? '0 : position + 1'b1;
        decel_interval = sat_add32(interval, INC_IV);
        lap_wrap       = (pos_adv == start_pos);
        laps_done      = (state == ST_SPIN) && step_tick && lap_wrap && (lap_count == LAST_LAP);
        landing        = (state == ST_DECEL) && step_tick && (pos_adv == target_latched);
        step_load      = 1'b0;
        step_value     = '0;
        if (accept) begin
            step_load  = 1'b1;
            step_value = BASE_IV;
        end else if (step_tick && (state == ST_SPIN)) begin
            step_load  = 1'b1;
            step_value = laps_done ? decel_interval : interval;
        end else if (step_tick && (state == ST_DECEL)) begin
            step_load  = 1'b1;
            step_value = landing ? HOLD_IV : decel_interval;
        end
    end

    step_timer u_step_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (step_load),
        .load_value (step_value),
        .tick       (step_tick)
    );

`ifdef ROULETTE_BLINK_EN
    logic blink_load;
    logic blink_tick;

    // Blink phase restarts at landing and re-arms every half-period in HOLD.
    always_comb begin
        blink_load = landing || ((state == ST_HOLD) && blink_tick);
    end

    step_timer u_blink_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (blink_load),
        .load_value (32'(BLINK_DIV)),
        .tick       (blink_tick)
    );
`else
    localparam int unused_blink_div = BLINK_DIV;
`endif

    // Spin FSM with position, lap counter and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            position       <= '0;
            start_pos      <= '0;
            target_latched <= '0;
            interval       <= BASE_IV;
            lap_count      <= '0;
            led_number     <= '0;
            result         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target_latched <= target;
                        start_pos      <= position;
                        interval       <= BASE_IV;
                        lap_count      <= '0;
                        busy           <= 1'b1;
                        state          <= ST_SPIN;
                    end
                end
                ST_SPIN: begin
                    if (step_tick) begin
                        position   <= pos_adv;
                        led_number <= pos_adv;
                        if (lap_wrap) begin
                            lap_count <= lap_count + 32'd1;
                        end
                        if (laps_done) begin
                            interval <= decel_interval;
                            state    <= ST_DECEL;
                        end
                    end
                end
                ST_DECEL: begin
                    if (step_tick) begin
                        position   <= pos_adv;
                        led_number <= pos_adv;
                        if (landing) begin
                            result <= pos_adv;
                            done   <= 1'b1;
                            state  <= ST_HOLD;
                        end else begin
                            interval <= decel_interval;
                        end
                    end
                end
                ST_HOLD: begin
`ifdef ROULETTE_BLINK_EN
                    if (blink_tick) begin
                        led_number <= (led_number == result) ? BLANK_CODE : result;
                    end
`endif
                    if (step_tick) begin
                        led_number <= result;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roulette_spin_sequencer.sv
// Randomized scoreboard bench for roulette_spin_sequencer. Each accepted spin
// is expanded by a timeline model into step events and a landing event; a
// negedge monitor consumes them and compares every output every cycle.
module tb_roulette_spin_sequencer;

    localparam int N     = 38;
    localparam int BASE  = 4;
    localparam int INC   = 2;
    localparam int LAPS  = 1;
    localparam int HOLD  = 10;
    localparam int BLINK = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       spin_req = 1'b0;
    logic [5:0] target = '0;
    logic       target_valid = 1'b0;
    logic [5:0] led_number;
    logic       busy;
    logic       done;
    logic [5:0] result;

    roulette_spin_sequencer #(
        .NUM_POCKETS (N),
        .BASE_DIV    (BASE),
        .STEP_INC    (INC),
        .MIN_LAPS    (LAPS),
        .HOLD_CYCLES (HOLD),
        .BLINK_DIV   (BLINK)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .spin_req     (spin_req),
        .target       (target),
        .target_valid (target_valid),
        .led_number   (led_number),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int pos;
    } ev_t;

    ev_t step_q[$];
    ev_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: wheel position after the last accepted spin, busy window,
    // landing cycle, and the expected steady LED / result values.
    int m_pos = 0;
    int m_busy_start = 0;
    int m_busy_end = 0;
    int m_hold_start = 0;
    int m_led = 0;
    int m_result = 0;
    int last_done_cyc = -1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expand one accepted spin into its full step timeline.
    task automatic model_accept(input int acc, input int t);
        int s;
        int tm;
        int d;
        s  = m_pos;
        tm = acc;
        for (int i = 1; i <= LAPS * N; i++) begin
            tm += BASE;
            step_q.push_back('{tm, (s + i) % N});
        end
        d = (t - s + N) % N;
        if (d == 0) d = N;
        for (int k = 1; k <= d; k++) begin
            tm += BASE + k * INC;
            step_q.push_back('{tm, (s + k) % N});
        end
        done_q.push_back('{tm, t});
        m_busy_start = acc;
        m_hold_start = tm;
        m_busy_end   = tm + HOLD;
        m_pos        = t;
        $display("spin: accept@%0d start=%0d target=%0d land@%0d", acc, s, t, tm);
    endtask

    // One request cycle; acc is the accept cycle, or -1 if the model rejects it.
    task automatic issue(input logic v, input int t, output int acc);
        int p;
        @(negedge clock);
        spin_req     = 1'b1;
        target_valid = v;
        target       = 6'(t);
        p            = cyc + 1;
        acc          = -1;
        if (v && t < N && p > m_busy_end) begin
            acc = p;
            model_accept(p, t);
        end else begin
            $display("request: valid=%0d target=%0d @%0d ignored", v, t, p);
        end
        @(negedge clock);
        spin_req     = 1'b0;
        target_valid = 1'b0;
        target       = 6'($urandom_range(0, 63));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc <= m_busy_end && guard < 4000) begin
            @(negedge clock);
            guard++;
        end
        check("idle_timeout", int'(guard < 4000), 1);
        check("idle_busy", busy, 0);
    endtask

    // Monitor: pop scoreboard entries as their cycle arrives and compare.
    always @(negedge clock) begin : mon
        ev_t ev;
        bit  exp_done;
        int  exp_l;
        if (reset) begin
            while (step_q.size() > 0 && step_q[0].cyc <= cyc) begin
                ev    = step_q.pop_front();
                m_led = ev.pos;
            end
            exp_done = (done_q.size() > 0) && (done_q[0].cyc == cyc);
            check("done", done, int'(exp_done));
            if (exp_done) begin
                ev       = done_q.pop_front();
                m_result = ev.pos;
                $display("land: cycle %0d result=%0d expected=%0d", cyc, result, ev.pos);
            end
            if (done) last_done_cyc = cyc;
            check("result", result, m_result);
            check("busy", busy, int'(cyc >= m_busy_start && cyc < m_busy_end));
            exp_l = m_led;
`ifdef ROULETTE_BLINK_EN
            if (cyc >= m_hold_start && cyc < m_busy_end && ((cyc - m_hold_start) / BLINK) % 2 == 1)
                exp_l = 63;
`endif
            check("led_number", led_number, exp_l);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int led_before;

        // Reset values.
        repeat (3) @(negedge clock);
        check("rst_led", led_number, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        reset = 1'b1;

        // Nominal spin to 5 from position 0: 152 spin + 50 decel clocks.
        issue(1'b1, 5, acc);
        wait_idle();
        check("nominal_latency", last_done_cyc - acc, 202);
        check("nominal_result", result, 5);

        // Request while busy is ignored; a later idle request is accepted.
        issue(1'b1, 20, acc);
        repeat (40) @(negedge clock);
        issue(1'b1, 9, acc2);
        wait_idle();
        check("busy_req_result", result, 20);
        issue(1'b1, 9, acc);
        wait_idle();
        check("idle_req_result", result, 9);

        // Invalid requests.
        led_before = led_number;
        issue(1'b0, 7, acc);
        issue(1'b1, 40, acc);
        repeat (3) @(negedge clock);
        check("invalid_led", led_number, led_before);
        check("invalid_busy", busy, 0);

        // Asynchronous reset in the middle of DECEL.
        issue(1'b1, 30, acc);
        while (cyc < acc + LAPS * N * BASE + 10) @(negedge clock);
        #2 reset = 1'b0;
        step_q.delete();
        done_q.delete();
        m_pos = 0; m_led = 0; m_result = 0;
        m_busy_start = 0; m_busy_end = 0; m_hold_start = 0;
        #1;
        check("async_rst_led", led_number, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_result", result, 0);
        @(negedge clock);
        reset = 1'b1;

        // Target equal to start position 0: full extra decel lap.
        issue(1'b1, 0, acc);
        wait_idle();
        check("same_pos_latency", last_done_cyc - acc,
              LAPS * N * BASE + N * BASE + INC * N * (N + 1) / 2);

        // Randomized traffic.
        for (int it = 0; it < 12; it++) begin
            int kind;
            int t;
            kind = $urandom_range(0, 9);
            repeat ($urandom_range(0, 4)) @(negedge clock);
            if (kind == 0) begin
                issue(1'b1, $urandom_range(38, 63), acc);
            end else if (kind == 1) begin
                issue(1'b0, $urandom_range(0, 37), acc);
            end else begin
                t = $urandom_range(0, 37);
                issue(1'b1, t, acc);
                if (kind > 7) begin
                    repeat ($urandom_range(5, 150)) @(negedge clock);
                    issue(1'b1, $urandom_range(0, 37), acc2);
                end
                wait_idle();
                check("rand_result", result, t);
            end
        end

        repeat (3) @(negedge clock);
        check("final_queue", step_q.size() + done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
